// File: rtl/sprite_fetch_arbiter.sv
// Two-requester round-robin burst fetcher: reads consecutive words from an
// asynchronous sprite ROM and streams them out through a one-entry output register.
module sprite_fetch_arbiter #(
  parameter int WIDTH = 8,
  parameter int ADDRW = 8,
  parameter int LENW  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [ADDRW-1:0] req0_base,
  input  logic [LENW-1:0]  req0_len,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [ADDRW-1:0] req1_base,
  input  logic [LENW-1:0]  req1_len,
  output logic             req1_ready,
  output logic [ADDRW-1:0] rom_addr,
  input  logic [WIDTH-1:0] rom_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id,
  output logic             out_last,
  output logic             busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high. reqN_ready is combinational and only ever raised in IDLE for a valid
  // requester; out_valid never depends on out_ready and holds until the beat transfers.

  typedef enum logic {IDLE = 1'b0, FETCH = 1'b1} state_t;

  state_t           state, state_nx;
  logic             prio;        // 0: req0 wins a tie, 1: req1 wins a tie
  logic             id_q;
  logic [LENW-1:0]  len_q;
  logic [LENW-1:0]  cnt;         // words captured so far in this burst
  logic             grant;
  logic             grant_id;
  logic [LENW-1:0]  grant_len;
  logic [ADDRW-1:0] grant_base;
  logic             advance;

  assign advance = !out_valid || out_ready;
  assign busy    = (state == FETCH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    grant      = 1'b0;
    grant_id   = 1'b0;
    grant_len  = '0;
    grant_base = '0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && (req0_valid || req1_valid)) begin
          grant      = 1'b1;
          grant_id   = !(req0_valid && (!req1_valid || !prio));
          grant_len  = grant_id ? req1_len : req0_len;
          grant_base = grant_id ? req1_base : req0_base;
          req0_ready = !grant_id;
          req1_ready = grant_id;
          if (grant_len != '0) state_nx = FETCH;
        end
      end
      FETCH: begin
        if (out_valid && out_ready && out_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio      <= 1'b0;
      id_q      <= 1'b0;
      len_q     <= '0;
      cnt       <= '0;
      rom_addr  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= 1'b0;
      out_last  <= 1'b0;
    end else if (state == IDLE) begin
      if (grant) begin
        prio  <= !grant_id;
        id_q  <= grant_id;
        len_q <= grant_len;
        cnt   <= '0;
        // A zero-length grant leaves the ROM address untouched.
        if (grant_len != '0) rom_addr <= grant_base;
      end
    end else if (advance) begin
      if (cnt != len_q) begin
        out_valid <= 1'b1;
        out_data  <= rom_data;
        out_id    <= id_q;
        out_last  <= (cnt + LENW'(1) == len_q);
        cnt       <= cnt + LENW'(1);
        if (cnt + LENW'(1) != len_q) rom_addr <= rom_addr + ADDRW'(1);
      end else begin
        // All words captured; the register drains once the final beat is taken.
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Directed bench for sprite_fetch_arbiter: a cycle table for arbitration and latency,
// plus hand sequences for wrap, stalls, zero-length and mid-burst reset.
module tb_sprite_fetch_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [7:0] req0_base, req1_base;
  logic [4:0] req0_len, req1_len;
  logic       req0_ready, req1_ready;
  logic [7:0] rom_addr;
  logic [7:0] rom_data;
  logic       out_valid, out_ready;
  logic [7:0] out_data;
  logic       out_id, out_last, busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  sprite_fetch_arbiter #(.WIDTH(8), .ADDRW(8), .LENW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_base(req0_base), .req0_len(req0_len), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_base(req1_base), .req1_len(req1_len), .req1_ready(req1_ready),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .out_last(out_last), .busy(busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // sprite ROM model: asynchronous read
  function automatic logic [7:0] rom_fn(input logic [7:0] a);
    logic [7:0] p;
    p = a * 8'd37;
    return p ^ 8'h5C;
  endfunction
  assign rom_data = rom_fn(rom_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       r0v;
    logic [7:0] r0b;
    logic [4:0] r0l;
    logic       r1v;
    logic [7:0] r1b;
    logic [4:0] r1l;
    logic       e_r0, e_r1, e_busy, e_ov;
    logic [7:0] e_addr;
    logic [7:0] e_waddr;
    logic       e_id, e_last;
  } vec_t;

  function automatic vec_t mk(input logic r0v, input logic [7:0] r0b, input logic [4:0] r0l,
                              input logic r1v, input logic [7:0] r1b, input logic [4:0] r1l,
                              input logic e_r0, input logic e_r1, input logic e_busy,
                              input logic e_ov, input logic [7:0] e_addr,
                              input logic [7:0] e_waddr, input logic e_id, input logic e_last);
    vec_t v;
    v.r0v = r0v; v.r0b = r0b; v.r0l = r0l;
    v.r1v = r1v; v.r1b = r1b; v.r1l = r1l;
    v.e_r0 = e_r0; v.e_r1 = e_r1; v.e_busy = e_busy; v.e_ov = e_ov;
    v.e_addr = e_addr; v.e_waddr = e_waddr; v.e_id = e_id; v.e_last = e_last;
    return v;
  endfunction

  task automatic idle_inputs();
    req0_valid = 1'b0; req0_base = 8'h00; req0_len = 5'd0;
    req1_valid = 1'b0; req1_base = 8'h00; req1_len = 5'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},      busy,       0);
    check({tag, "_out_valid"}, out_valid,  0);
    check({tag, "_out_last"},  out_last,   0);
    check({tag, "_out_id"},    out_id,     0);
    check({tag, "_out_data"},  out_data,   0);
    check({tag, "_rom_addr"},  rom_addr,   0);
    check({tag, "_req0_ready"}, req0_ready, 0);
    check({tag, "_req1_ready"}, req1_ready, 0);
  endtask

  // driver task: single-requester burst with an out_ready stall mask, scoreboarded
  task automatic run_burst(input string tag, input logic id, input logic [7:0] base,
                           input logic [4:0] len, input logic [31:0] stall_mask);
    logic       prev_stall;
    logic [7:0] prev_data, prev_addr, got;
    logic       done;
    @(negedge clk);
    idle_inputs();
    out_ready = 1'b1;
    if (id) begin req1_valid = 1'b1; req1_base = base; req1_len = len; end
    else    begin req0_valid = 1'b1; req0_base = base; req0_len = len; end
    #1;
    check({tag, "_grant_ready"}, id ? req1_ready : req0_ready, 1);
    check({tag, "_other_ready"}, id ? req0_ready : req1_ready, 0);
    for (int k = 0; k < len; k++) exp_q.push_back(rom_fn(base + 8'(k)));
    prev_stall = 1'b0; prev_data = '0; prev_addr = '0; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      idle_inputs();
      out_ready = !stall_mask[i % 32];
      #1;
      if (i > 0) check({tag, "_busy_in_burst"}, busy, 1);
      if (prev_stall && out_valid) begin
        check({tag, "_stall_data_hold"}, out_data, prev_data);
        check({tag, "_stall_addr_hold"}, rom_addr, prev_addr);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_addr  = rom_addr;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_beat"}, 1, 0);
          done = 1'b1;
        end else begin
          got = exp_q.pop_front();
          check({tag, "_data"}, out_data, got);
          check({tag, "_id"},   out_id,   id);
          check({tag, "_last"}, out_last, exp_q.size() == 0);
          if (exp_q.size() == 0) done = 1'b1;
        end
      end
    end
    if (!done) begin
      check({tag, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check({tag, "_idle_busy"},      busy,      0);
    check({tag, "_idle_out_valid"}, out_valid, 0);
  endtask

  vec_t vecs[23];

  initial begin
    // tie after reset, req0 first; then req1; repeat tie goes to req0; then a len-4 burst
    vecs[0]  = mk(1,8'h20,2, 1,8'h40,2, 1,0,0,0, 8'h00, 8'h00,0,0);
    vecs[1]  = mk(0,8'h00,0, 1,8'h40,2, 0,0,1,0, 8'h20, 8'h00,0,0);
    vecs[2]  = mk(0,8'h00,0, 1,8'h40,2, 0,0,1,1, 8'h21, 8'h20,0,0);
    vecs[3]  = mk(0,8'h00,0, 1,8'h40,2, 0,0,1,1, 8'h21, 8'h21,0,1);
    vecs[4]  = mk(0,8'h00,0, 1,8'h40,2, 0,1,0,0, 8'h21, 8'h00,0,0);
    vecs[5]  = mk(0,8'h00,0, 0,8'h00,0, 0,0,1,0, 8'h40, 8'h00,0,0);
    vecs[6]  = mk(0,8'h00,0, 0,8'h00,0, 0,0,1,1, 8'h41, 8'h40,1,0);
    vecs[7]  = mk(0,8'h00,0, 0,8'h00,0, 0,0,1,1, 8'h41, 8'h41,1,1);
    vecs[8]  = mk(1,8'h30,2, 1,8'h50,2, 1,0,0,0, 8'h41, 8'h00,0,0);
    vecs[9]  = mk(0,8'h00,0, 1,8'h50,2, 0,0,1,0, 8'h30, 8'h00,0,0);
    vecs[10] = mk(0,8'h00,0, 1,8'h50,2, 0,0,1,1, 8'h31, 8'h30,0,0);
    vecs[11] = mk(0,8'h00,0, 1,8'h50,2, 0,0,1,1, 8'h31, 8'h31,0,1);
    vecs[12] = mk(0,8'h00,0, 1,8'h50,2, 0,1,0,0, 8'h31, 8'h00,0,0);
    vecs[13] = mk(0,8'h00,0, 0,8'h00,0, 0,0,1,0, 8'h50, 8'h00,0,0);
    vecs[14] = mk(0,8'h00,0, 0,8'h00,0, 0,0,1,1, 8'h51, 8'h50,1,0);
    vecs[15] = mk(0,8'h00,0, 0,8'h00,0, 0,0,1,1, 8'h51, 8'h51,1,1);
    vecs[16] = mk(1,8'h10,4, 0,8'h00,0, 1,0,0,0, 8'h51, 8'h00,0,0);
    vecs[17] = mk(0,8'h00,0, 0,8'h00,0, 0,0,1,0, 8'h10, 8'h00,0,0);
    vecs[18] = mk(0,8'h00,0, 0,8'h00,0, 0,0,1,1, 8'h11, 8'h10,0,0);
    vecs[19] = mk(0,8'h00,0, 0,8'h00,0, 0,0,1,1, 8'h12, 8'h11,0,0);
    vecs[20] = mk(0,8'h00,0, 0,8'h00,0, 0,0,1,1, 8'h13, 8'h12,0,0);
    vecs[21] = mk(0,8'h00,0, 0,8'h00,0, 0,0,1,1, 8'h13, 8'h13,0,1);
    vecs[22] = mk(0,8'h00,0, 0,8'h00,0, 0,0,0,0, 8'h13, 8'h00,0,0);

    rst_n = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    req0_valid = 1'b1; req0_len = 5'd3;
    req1_valid = 1'b1; req1_len = 5'd3;
    #1;
    check_all_zero("reset");
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    for (int v = 0; v < 23; v++) begin
      @(negedge clk);
      req0_valid = vecs[v].r0v; req0_base = vecs[v].r0b; req0_len = vecs[v].r0l;
      req1_valid = vecs[v].r1v; req1_base = vecs[v].r1b; req1_len = vecs[v].r1l;
      out_ready = 1'b1;
      #1;
      check($sformatf("vec%0d_req0_ready", v), req0_ready, vecs[v].e_r0);
      check($sformatf("vec%0d_req1_ready", v), req1_ready, vecs[v].e_r1);
      check($sformatf("vec%0d_busy", v),       busy,       vecs[v].e_busy);
      check($sformatf("vec%0d_out_valid", v),  out_valid,  vecs[v].e_ov);
      check($sformatf("vec%0d_rom_addr", v),   rom_addr,   vecs[v].e_addr);
      if (vecs[v].e_ov) begin
        check($sformatf("vec%0d_out_data", v), out_data, rom_fn(vecs[v].e_waddr));
        check($sformatf("vec%0d_out_id", v),   out_id,   vecs[v].e_id);
        check($sformatf("vec%0d_out_last", v), out_last, vecs[v].e_last);
      end
    end

    run_burst("wrap", 1'b1, 8'hFE, 5'd4, 32'h0);
    run_burst("stall", 1'b0, 8'h60, 5'd6, 32'h0000_0038);
    run_burst("stall_rand", 1'b1, 8'h90, 5'd7, 32'h0000_1A6C);

    // zero-length request: ready pulse only
    @(negedge clk);
    idle_inputs();
    req1_valid = 1'b1; req1_base = 8'hC0; req1_len = 5'd0;
    #1;
    check("len0_ready", req1_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      check("len0_busy", busy, 0);
      check("len0_out_valid", out_valid, 0);
    end

    // reset during beat 2 of an 8-word burst
    @(negedge clk);
    idle_inputs();
    req0_valid = 1'b1; req0_base = 8'h80; req0_len = 5'd8;
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    check("midrst_beat2_valid", out_valid, 1);
    check("midrst_beat2_data",  out_data,  rom_fn(8'h81));
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_len = 5'd2;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("postrst_busy", busy, 0);
      check("postrst_out_valid", out_valid, 0);
    end
    // pointer back to favouring req0 after reset
    @(negedge clk);
    req0_valid = 1'b1; req0_base = 8'hA0; req0_len = 5'd0;
    req1_valid = 1'b1; req1_base = 8'hB0; req1_len = 5'd0;
    #1;
    check("postrst_tie_req0", req0_ready, 1);
    check("postrst_tie_req1", req1_ready, 0);
    run_burst("postrst", 1'b0, 8'h44, 5'd3, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
